// File: rtl/up_counter_pkg.sv
// Shared width, type and default parameter values for the up_counter block.
package up_counter_pkg;

   localparam int unsigned COUNTER_WIDTH = 8;

   typedef logic [COUNTER_WIDTH-1:0] counter_t;

   localparam int unsigned DEFAULT_RESET_VALUE = 32'd0;
   localparam int unsigned DEFAULT_STEP        = 32'd1;
   localparam int unsigned DEFAULT_MAX_VALUE   = (32'd1 << COUNTER_WIDTH) - 32'd1;
   localparam int unsigned DEFAULT_SATURATE    = 32'd0;

endpackage

// File: rtl/up_counter_next.sv
// Combinational next-value calculator: applies STEP and the wrap/saturate rule
// at the terminal value; terminal flags an enabled advance that hits that rule.
module up_counter_next
   import up_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = COUNTER_WIDTH,
   parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE,
   parameter int unsigned STEP        = DEFAULT_STEP,
   parameter int unsigned MAX_VALUE   = DEFAULT_MAX_VALUE,
   parameter int unsigned SATURATE    = DEFAULT_SATURATE
) (
   input  logic [WIDTH-1:0] value,
   input  logic             count,
   output logic [WIDTH-1:0] next_value,
   output logic             terminal
);

   localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_VALUE);
   localparam logic [WIDTH-1:0] WRAP_TO = (SATURATE != 32'd0) ? WIDTH'(MAX_VALUE)
                                                              : WIDTH'(RESET_VALUE);

   logic [WIDTH:0] sum_s;
   logic           over_s;

   // One extra bit keeps the carry, so sum > MAX is the same test as value > MAX - STEP.
   assign sum_s  = {1'b0, value} + STEP_W;
   assign over_s = (sum_s > MAX_W);

   // Select hold, plain increment, or the wrap/saturate target.
   always_comb begin
      next_value = value;
      terminal   = 1'b0;
      if (count) begin
         if (over_s) begin
            next_value = WRAP_TO;
            terminal   = 1'b1;
         end else begin
            next_value = sum_s[WIDTH-1:0];
            terminal   = 1'b0;
         end
      end else begin
         next_value = value;
         terminal   = 1'b0;
      end
   end

endmodule

// File: rtl/up_counter.sv
// Registered up-counter with count enable and synchronous active-high reset;
// optional reset value, step, terminal value and saturating mode.
module up_counter
   import up_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = COUNTER_WIDTH,
   parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE,
   parameter int unsigned STEP        = DEFAULT_STEP,
   parameter int unsigned MAX_VALUE   = (WIDTH == COUNTER_WIDTH) ? DEFAULT_MAX_VALUE
                                        : ((32'd1 << WIDTH) - 32'd1),
   parameter int unsigned SATURATE    = DEFAULT_SATURATE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             count,
   output logic [WIDTH-1:0] data_o
);

   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

   if (WIDTH < 32'd1 || WIDTH > 32'd31) begin : g_bad_width
      $error("up_counter: WIDTH must be in 1..31");
   end
   if (STEP < 32'd1 || STEP > MAX_VALUE) begin : g_bad_step
      $error("up_counter: STEP must satisfy 1 <= STEP <= MAX_VALUE");
   end
   if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
      $error("up_counter: RESET_VALUE must not exceed MAX_VALUE");
   end
   if (64'(MAX_VALUE) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("up_counter: MAX_VALUE must fit in WIDTH bits");
   end

   logic [WIDTH-1:0] value_r;
   logic [WIDTH-1:0] next_s;
   logic             terminal_s;

   up_counter_next #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE),
      .STEP        (STEP),
      .MAX_VALUE   (MAX_VALUE),
      .SATURATE    (SATURATE)
   ) u_next (
      .value      (value_r),
      .count      (count),
      .next_value (next_s),
      .terminal   (terminal_s)
   );

   // Counter register: reset wins, otherwise an enabled edge takes the computed next value.
   always_ff @(posedge clock) begin
      if (reset) begin
         value_r <= RESET_W;
      end else if (count || terminal_s) begin
         value_r <= next_s;
      end else begin
         value_r <= value_r;
      end
   end

   assign data_o = value_r;

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench: a wrapping and a saturating up_counter share the same
// inputs; vector table, wrap/reset corner sequences, then a random stream.
module tb_up_counter;
   import up_counter_pkg::*;

   logic     clock;
   logic     reset;
   logic     count;
   counter_t data_wrap;
   counter_t data_sat;

   int total = 0;
   int bad   = 0;

   up_counter dut_wrap (
      .clock  (clock),
      .reset  (reset),
      .count  (count),
      .data_o (data_wrap)
   );

   up_counter #(.SATURATE(32'd1)) dut_sat (
      .clock  (clock),
      .reset  (reset),
      .count  (count),
      .data_o (data_sat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic     rst;
      logic     cnt;
      counter_t exp_wrap;
      counter_t exp_sat;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input counter_t act, input counter_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply inputs just after an edge, then wait for the next edge and settle.
   task automatic step(input logic r, input logic c);
      reset = r;
      count = c;
      @(posedge clock);
      #1;
   endtask

   initial begin
      counter_t m_wrap;
      counter_t m_sat;
      logic     r;
      logic     c;

      reset = 1'b0;
      count = 1'b0;

      vecs[0]  = '{1'b1, 1'b1, 8'd0, 8'd0};
      vecs[1]  = '{1'b1, 1'b1, 8'd0, 8'd0};
      vecs[2]  = '{1'b0, 1'b1, 8'd1, 8'd1};
      vecs[3]  = '{1'b0, 1'b1, 8'd2, 8'd2};
      vecs[4]  = '{1'b0, 1'b1, 8'd3, 8'd3};
      vecs[5]  = '{1'b0, 1'b1, 8'd4, 8'd4};
      vecs[6]  = '{1'b0, 1'b1, 8'd5, 8'd5};
      vecs[7]  = '{1'b0, 1'b0, 8'd5, 8'd5};
      vecs[8]  = '{1'b0, 1'b0, 8'd5, 8'd5};
      vecs[9]  = '{1'b0, 1'b0, 8'd5, 8'd5};
      vecs[10] = '{1'b0, 1'b1, 8'd6, 8'd6};
      vecs[11] = '{1'b1, 1'b0, 8'd0, 8'd0};

      @(posedge clock);
      #1;

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].cnt);
         check($sformatf("vec%0d_wrap", i), data_wrap, vecs[i].exp_wrap);
         check($sformatf("vec%0d_sat", i), data_sat, vecs[i].exp_sat);
      end

      // Full wrap from 0: 256 enabled edges.
      for (int i = 1; i <= 256; i++) begin
         step(1'b0, 1'b1);
         if (i == 254) begin
            check("wrap_254", data_wrap, 8'd254);
            check("sat_254", data_sat, 8'd254);
         end else if (i == 255) begin
            check("wrap_255", data_wrap, 8'd255);
            check("sat_255", data_sat, 8'd255);
         end else if (i == 256) begin
            check("wrap_to_0", data_wrap, 8'd0);
            check("sat_hold", data_sat, 8'd255);
         end
      end
      step(1'b0, 1'b1);
      check("wrap_after_0", data_wrap, 8'd1);
      check("sat_stays", data_sat, 8'd255);

      // Reset mid-count at 100.
      step(1'b1, 1'b0);
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1);
      end
      check("mid_at_100", data_wrap, 8'd100);
      step(1'b1, 1'b1);
      check("mid_reset_wrap", data_wrap, 8'd0);
      check("mid_reset_sat", data_sat, 8'd0);
      step(1'b0, 1'b1);
      check("mid_after_wrap", data_wrap, 8'd1);
      check("mid_after_sat", data_sat, 8'd1);

      // Random stream against a reference model.
      step(1'b1, 1'b0);
      m_wrap = 8'd0;
      m_sat  = 8'd0;
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 31) == 0);
         c = 1'($urandom_range(0, 3) != 0);
         step(r, c);
         if (r) begin
            m_wrap = 8'd0;
            m_sat  = 8'd0;
         end else if (c) begin
            m_wrap = m_wrap + 8'd1;
            m_sat  = (m_sat == 8'd255) ? 8'd255 : m_sat + 8'd1;
         end else begin
            m_wrap = m_wrap;
            m_sat  = m_sat;
         end
         check("rand_wrap", data_wrap, m_wrap);
         check("rand_sat", data_sat, m_sat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
